data_memory_dump: RTL and testbench



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/data_memory_dump_if.sv | 43 ++++
 rtl/dmem_read_pipe.sv | 53 +++++
 rtl/data_memory_dump.sv | 177 +++++++++++++++++
 tb/tb_data_memory_dump.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data memory with dump port.
//   dump_state_t     : dump FSM state encoding (IDLE, ISSUE, WAIT, PRESENT, DONE)
//   MAX_READ_LATENCY : largest supported READ_LATENCY
//   DUMP_STATE_BITS  : width of the dump FSM state encoding
//   WAIT_CNT_BITS    : width of the dump latency counter
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int DUMP_STATE_BITS  = 3;
    localparam int WAIT_CNT_BITS    = $clog2(MAX_READ_LATENCY);

    typedef enum logic [DUMP_STATE_BITS-1:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } dump_state_t;

endpackage

// File: rtl/data_memory_dump_if.sv
// -----------------------------------------------------------------------------
// data_memory_dump_if
// Bundles the CPU load/store bus and the dump stream of data_memory_dump.
//   master : CPU / dump consumer side (drives requests and dump_ready)
//   slave  : memory side (drives load data and dump beats)
// Handshake: a dump beat transfers on a clock edge where dump_valid and
// dump_ready are both 1; while dump_valid=1 and dump_ready=0 the memory holds
// dump_addr/dump_data stable. dump_valid never depends on dump_ready.
// CPU loads have no back-pressure: read_valid is a one-cycle pulse per load.
// -----------------------------------------------------------------------------
interface data_memory_dump_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 20
);
    logic                     MemRead;
    logic                     MemWrite;
    logic                     ByteEnable;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [DATA_WIDTH-1:0]    mem_read_data;
    logic                     read_valid;
    logic                     dump_start;
    logic                     dump_ready;
    logic                     dump_valid;
    logic [ADDRESS_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0]    dump_data;
    logic                     dump_busy;
    logic                     dump_done;

    modport master (
        output MemRead, MemWrite, ByteEnable, address, mem_write_data,
        output dump_start, dump_ready,
        input  mem_read_data, read_valid,
        input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  MemRead, MemWrite, ByteEnable, address, mem_write_data,
        input  dump_start, dump_ready,
        output mem_read_data, read_valid,
        output dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/dmem_read_pipe.sv
// -----------------------------------------------------------------------------
// dmem_read_pipe
// LATENCY-deep valid/data shift register for the CPU load path.
//   clk     in   clock
//   i_flush in   synchronous flush, clears valid and data stages
//   i_valid in   load sampled this edge
//   i_data  in   load word captured this edge
//   o_valid out  last stage valid (one-cycle pulse per load)
//   o_data  out  last stage data; holds its value while no load passes
// A data stage only loads when the stage before it carries a valid load, so
// the output keeps the last returned word during bubbles.
// -----------------------------------------------------------------------------
module dmem_read_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [LATENCY-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data [LATENCY];

    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_valid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                if (r_valid[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/data_memory_dump.sv
// -----------------------------------------------------------------------------
// data_memory_dump
// Word/byte data memory for the MEM stage with READ_LATENCY-cycle loads and an
// optional handshaked dump stream that walks every word in address order.
//   clk          in   clock
//   rst          in   synchronous active-high reset (memory contents kept)
//   bus          slave modport of data_memory_dump_if (CPU bus + dump stream)
//   o_dump_state out  dump FSM state, for debug and checkers
// Optional feature macro: DATA_MEMORY_DUMP_EN. When undefined the dump FSM is
// not built, the dump outputs are tied to 0 and dump_start/dump_ready are
// ignored; CPU behaviour is the same in both builds.
// Load timing: MemRead is sampled at edge N and read_valid/mem_read_data are
// high/valid in the cycle before edge N+READ_LATENCY, so a consumer samples
// them at edge N+READ_LATENCY. Same-edge load and store is read-first.
// Requires MEM_SIZE >= 2, MEM_SIZE <= 2**ADDRESS_WIDTH, 1 <= READ_LATENCY <= 4,
// BYTE_WIDTH < DATA_WIDTH.
// -----------------------------------------------------------------------------
module data_memory_dump
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int READ_LATENCY  = 1,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_dump_if.slave bus,
    output dump_state_t       o_dump_state
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDRESS_WIDTH:0] MEM_SIZE_W = (ADDRESS_WIDTH+1)'(MEM_SIZE);

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    logic                  w_cpu_in_range;
    logic [IDX_W-1:0]      w_cpu_idx;
    logic [DATA_WIDTH-1:0] w_mem_word;
    logic [DATA_WIDTH-1:0] w_load_word;
    logic                  w_pipe_valid;
    logic [DATA_WIDTH-1:0] w_pipe_data;

    // Out-of-range addresses must not alias onto a real word via the index.
    assign w_cpu_in_range = {1'b0, bus.address} < MEM_SIZE_W;
    assign w_cpu_idx      = bus.address[IDX_W-1:0];
    assign w_mem_word     = r_mem[w_cpu_idx];

    always_comb begin
        w_load_word = '0;
        if (w_cpu_in_range) begin
            if (bus.ByteEnable) begin
                w_load_word = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_mem_word[BYTE_WIDTH-1:0]};
            end else begin
                w_load_word = w_mem_word;
            end
        end
    end

    // Storage has no reset; the load path samples the array before this
    // edge's store lands, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && w_cpu_in_range) begin
            if (bus.ByteEnable) begin
                r_mem[w_cpu_idx][BYTE_WIDTH-1:0] <= bus.mem_write_data[BYTE_WIDTH-1:0];
            end else begin
                r_mem[w_cpu_idx] <= bus.mem_write_data;
            end
        end
    end

    dmem_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .clk     (clk),
        .i_flush (rst),
        .i_valid (bus.MemRead),
        .i_data  (w_load_word),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    assign bus.read_valid    = w_pipe_valid;
    assign bus.mem_read_data = w_pipe_data;

`ifdef DATA_MEMORY_DUMP_EN
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [WAIT_CNT_BITS-1:0] LAT_LAST  = WAIT_CNT_BITS'(READ_LATENCY - 1);

    dump_state_t              r_state, w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_ptr, w_ptr_next;
    logic [DATA_WIDTH-1:0]    r_dump_data, w_dump_data_next;
    logic [WAIT_CNT_BITS-1:0] r_wait_cnt, w_wait_cnt_next;
    logic [DATA_WIDTH-1:0]    w_dump_word;

    // The pointer never exceeds MEM_SIZE-1, so the low bits index directly.
    assign w_dump_word = r_mem[r_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_dump_data <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_dump_data <= w_dump_data_next;
            r_wait_cnt  <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_dump_data_next = r_dump_data;
        w_wait_cnt_next  = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (bus.dump_start) begin
                    w_state_next = ISSUE;
                    w_ptr_next   = '0;
                end
            end
            ISSUE: begin
                // Any CPU access this cycle wins; the word is captured only on
                // a quiet cycle, so stores before issue are reflected.
                if (!(bus.MemRead || bus.MemWrite)) begin
                    w_dump_data_next = w_dump_word;
                    w_wait_cnt_next  = '0;
                    w_state_next     = WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == LAT_LAST) begin
                    w_state_next = PRESENT;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            PRESENT: begin
                if (bus.dump_ready) begin
                    if (r_ptr == LAST_ADDR) begin
                        w_state_next = DONE;
                    end else begin
                        w_ptr_next   = r_ptr + 1'b1;
                        w_state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.dump_valid = (r_state == PRESENT);
    assign bus.dump_busy  = (r_state != IDLE);
    assign bus.dump_done  = (r_state == DONE);
    assign bus.dump_addr  = r_ptr;
    assign bus.dump_data  = r_dump_data;
    assign o_dump_state   = r_state;
`else
    assign bus.dump_valid = 1'b0;
    assign bus.dump_busy  = 1'b0;
    assign bus.dump_done  = 1'b0;
    assign bus.dump_addr  = '0;
    assign bus.dump_data  = '0;
    assign o_dump_state   = IDLE;
`endif

endmodule

// File: tb/tb_data_memory_dump.sv
// -----------------------------------------------------------------------------
// tb_data_memory_dump
// Two instances: u_a (ADDRESS_WIDTH=9, MEM_SIZE=256, READ_LATENCY=2) for the
// CPU load/store cases, u_b (MEM_SIZE=16, READ_LATENCY=3) for the dump stream.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_memory_dump;
    import dmem_pkg::*;

    localparam int DW   = 20;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    logic clk;
    logic rst;

    data_memory_dump_if #(.ADDRESS_WIDTH(9), .DATA_WIDTH(DW)) bus_a ();
    data_memory_dump_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(DW)) bus_b ();
    dump_state_t st_a;
    dump_state_t st_b;

    data_memory_dump #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(9), .MEM_SIZE(256),
        .READ_LATENCY(LAT_A), .BYTE_WIDTH(8)
    ) u_a (
        .clk(clk), .rst(rst), .bus(bus_a), .o_dump_state(st_a)
    );

    data_memory_dump #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(8), .MEM_SIZE(16),
        .READ_LATENCY(LAT_B), .BYTE_WIDTH(8)
    ) u_b (
        .clk(clk), .rst(rst), .bus(bus_b), .o_dump_state(st_b)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats    = 0;
    int done_cnt = 0;

    logic [DW-1:0] exp_a_q[$];
    int            due_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int            due_b_q[$];
    logic [7:0]    dexp_addr_q[$];
    logic [DW-1:0] dexp_data_q[$];
    logic [DW-1:0] model_a [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge dump handshake, advance to the falling
    // edge, then score every output event of this cycle.
    task automatic tick();
        logic          acc_b;
        logic          hold_b;
        logic [7:0]    pre_addr;
        logic [DW-1:0] pre_data;
        acc_b    = bus_b.dump_valid && bus_b.dump_ready;
        hold_b   = bus_b.dump_valid && !bus_b.dump_ready;
        pre_addr = bus_b.dump_addr;
        pre_data = bus_b.dump_data;
        @(negedge clk);
        cyc++;
        if (bus_a.read_valid === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                chk("a_spurious_valid", 32'(bus_a.read_valid), 0);
            end else begin
                chk("a_rdata", 32'(bus_a.mem_read_data), 32'(exp_a_q.pop_front()));
                chk("a_latency", cyc, due_a_q.pop_front());
            end
        end else if (due_a_q.size() != 0 && due_a_q[0] <= cyc) begin
            chk("a_missing_valid", 32'(bus_a.read_valid), 1);
            void'(exp_a_q.pop_front());
            void'(due_a_q.pop_front());
        end
        if (bus_b.read_valid === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                chk("b_spurious_valid", 32'(bus_b.read_valid), 0);
            end else begin
                chk("b_rdata", 32'(bus_b.mem_read_data), 32'(exp_b_q.pop_front()));
                chk("b_latency", cyc, due_b_q.pop_front());
            end
        end else if (due_b_q.size() != 0 && due_b_q[0] <= cyc) begin
            chk("b_missing_valid", 32'(bus_b.read_valid), 1);
            void'(exp_b_q.pop_front());
            void'(due_b_q.pop_front());
        end
        if (acc_b === 1'b1) begin
            if (dexp_addr_q.size() == 0) begin
                chk("dump_extra_beat", 32'(acc_b), 0);
            end else begin
                chk("dump_addr", 32'(pre_addr), 32'(dexp_addr_q.pop_front()));
                chk("dump_data", 32'(pre_data), 32'(dexp_data_q.pop_front()));
                beats++;
            end
        end
        if (hold_b === 1'b1) begin
            chk("dump_hold_valid", 32'(bus_b.dump_valid), 1);
            chk("dump_hold_addr", 32'(bus_b.dump_addr), 32'(pre_addr));
            chk("dump_hold_data", 32'(bus_b.dump_data), 32'(pre_data));
        end
        if (bus_b.dump_done === 1'b1) done_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // driver tasks
    task automatic wr_a(input int addr, input logic [DW-1:0] data, input logic be);
        bus_a.MemWrite = 1'b1; bus_a.address = 9'(addr);
        bus_a.mem_write_data = data; bus_a.ByteEnable = be;
        tick();
        bus_a.MemWrite = 1'b0;
    endtask

    task automatic rd_a(input int addr, input logic be, input logic [DW-1:0] exp);
        bus_a.MemRead = 1'b1; bus_a.address = 9'(addr); bus_a.ByteEnable = be;
        exp_a_q.push_back(exp);
        due_a_q.push_back(cyc + LAT_A);
        tick();
        bus_a.MemRead = 1'b0;
    endtask

    task automatic wr_b(input int addr, input logic [DW-1:0] data);
        bus_b.MemWrite = 1'b1; bus_b.address = 8'(addr);
        bus_b.mem_write_data = data; bus_b.ByteEnable = 1'b0;
        tick();
        bus_b.MemWrite = 1'b0;
    endtask

    task automatic rd_b(input int addr, input logic [DW-1:0] exp);
        bus_b.MemRead = 1'b1; bus_b.address = 8'(addr); bus_b.ByteEnable = 1'b0;
        exp_b_q.push_back(exp);
        due_b_q.push_back(cyc + LAT_B);
        tick();
        bus_b.MemRead = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < 16; i++) begin
            dexp_addr_q.push_back(8'(i));
            dexp_data_q.push_back(DW'(i * 3));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int            addr;
        int            op;
        int            k;
        logic          be;

        rst = 1'b1;
        bus_a.MemRead = 0; bus_a.MemWrite = 0; bus_a.ByteEnable = 0;
        bus_a.address = '0; bus_a.mem_write_data = '0;
        bus_a.dump_start = 0; bus_a.dump_ready = 0;
        bus_b.MemRead = 0; bus_b.MemWrite = 0; bus_b.ByteEnable = 0;
        bus_b.address = '0; bus_b.mem_write_data = '0;
        bus_b.dump_start = 0; bus_b.dump_ready = 0;
        idle(3);
        rst = 1'b0;

        // reset state
        chk("rst_read_valid", 32'(bus_a.read_valid), 0);
        chk("rst_read_data", 32'(bus_a.mem_read_data), 0);
        chk("rst_dump_valid", 32'(bus_b.dump_valid), 0);
        chk("rst_dump_busy", 32'(bus_b.dump_busy), 0);
        chk("rst_dump_done", 32'(bus_b.dump_done), 0);
        chk("rst_dump_addr", 32'(bus_b.dump_addr), 0);
        chk("rst_dump_data", 32'(bus_b.dump_data), 0);
        chk("rst_state", 32'(st_b), 32'(IDLE));

        // basic word store/load, latency 2
        wr_a(5, 20'hABCDE, 1'b0);
        rd_a(5, 1'b0, 20'hABCDE);
        idle(3);

        // byte lane store and byte load, back-to-back loads
        wr_a(9, 20'hFFFFF, 1'b0);
        wr_a(9, 20'h5A53C, 1'b1);
        rd_a(9, 1'b0, 20'hFFF3C);
        rd_a(9, 1'b1, 20'h0003C);
        idle(3);

        // out-of-range store dropped (300 would alias to 44), load returns 0
        wr_a(44, 20'h00444, 1'b0);
        wr_a(300, 20'h12345, 1'b0);
        rd_a(44, 1'b0, 20'h00444);
        rd_a(300, 1'b0, 20'h00000);
        rd_a(300, 1'b1, 20'h00000);
        idle(3);

        // same-cycle load and store is read-first
        wr_a(7, 20'h00011, 1'b0);
        bus_a.MemRead = 1'b1; bus_a.MemWrite = 1'b1; bus_a.address = 9'd7;
        bus_a.ByteEnable = 1'b0; bus_a.mem_write_data = 20'h00022;
        exp_a_q.push_back(20'h00011);
        due_a_q.push_back(cyc + LAT_A);
        tick();
        bus_a.MemWrite = 1'b0; bus_a.MemRead = 1'b0;
        rd_a(7, 1'b0, 20'h00022);
        idle(4);
        chk("hold_read_valid", 32'(bus_a.read_valid), 0);
        chk("hold_read_data", 32'(bus_a.mem_read_data), 32'(20'h00022));

        // random mixed traffic against a small reference model
        for (int i = 0; i < 8; i++) begin
            d = 20'($urandom_range(0, 20'hFFFFF));
            model_a[100 + i] = d;
            wr_a(100 + i, d, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            addr = $urandom_range(100, 107);
            be   = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 2);
            d    = 20'($urandom_range(0, 20'hFFFFF));
            bus_a.address = 9'(addr); bus_a.ByteEnable = be; bus_a.mem_write_data = d;
            bus_a.MemRead  = (op != 1);
            bus_a.MemWrite = (op != 0);
            if (op != 1) begin
                e = be ? {12'h000, model_a[addr][7:0]} : model_a[addr];
                exp_a_q.push_back(e);
                due_a_q.push_back(cyc + LAT_A);
            end
            if (op != 0) begin
                if (be) model_a[addr][7:0] = d[7:0];
                else    model_a[addr] = d;
            end
            tick();
            bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0;
        end
        idle(4);
        chk("a_queue_drained", exp_a_q.size(), 0);

        // preload u_b with i*3
        for (int i = 0; i < 16; i++) wr_b(i, DW'(i * 3));

`ifdef DATA_MEMORY_DUMP_EN
        // dump 1: stalled by CPU loads in ISSUE, then ready toggling
        push_dump();
        bus_b.dump_start = 1'b1;
        tick();
        bus_b.dump_start = 1'b0;
        chk("dump_busy_start", 32'(bus_b.dump_busy), 1);
        for (int i = 0; i < 6; i++) begin
            bus_b.MemRead = 1'b1; bus_b.address = 8'(i); bus_b.ByteEnable = 1'b0;
            exp_b_q.push_back(DW'(i * 3));
            due_b_q.push_back(cyc + LAT_B);
            tick();
            chk("dump_stall_valid", 32'(bus_b.dump_valid), 0);
            chk("dump_stall_state", 32'(st_b), 32'(ISSUE));
        end
        bus_b.MemRead = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            bus_b.dump_ready = (k % 2 == 0);
            bus_b.dump_start = (k == 10);  // must be ignored mid-dump
            tick();
            k++;
        end
        bus_b.dump_ready = 1'b0; bus_b.dump_start = 1'b0;
        chk("dump1_finished", done_cnt, 1);
        chk("dump1_beats", beats, 16);
        chk("dump1_queue_empty", dexp_addr_q.size(), 0);
        idle(3);
        chk("dump1_done_once", done_cnt, 1);
        chk("dump1_idle_busy", 32'(bus_b.dump_busy), 0);
        chk("b_queue_drained", exp_b_q.size(), 0);

        // dump 2: reset while beat 4 is presented
        push_dump();
        bus_b.dump_start = 1'b1;
        tick();
        bus_b.dump_start = 1'b0;
        bus_b.dump_ready = 1'b1;
        k = 0;
        while (!(bus_b.dump_valid === 1'b1 && bus_b.dump_addr == 8'd4) && k < 200) begin
            tick();
            k++;
        end
        chk("rst_beat4_reached", 32'(bus_b.dump_valid), 1);
        bus_b.dump_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(bus_b.dump_valid), 0);
        chk("midrst_busy", 32'(bus_b.dump_busy), 0);
        chk("midrst_done", 32'(bus_b.dump_done), 0);
        chk("midrst_state", 32'(st_b), 32'(IDLE));
        dexp_addr_q.delete();
        dexp_data_q.delete();
        idle(3);
        chk("midrst_no_done", done_cnt, 1);
        chk("midrst_beats", beats, 20);

        // dump 3: restart from address 0 after reset
        push_dump();
        bus_b.dump_start = 1'b1;
        tick();
        bus_b.dump_start = 1'b0;
        bus_b.dump_ready = 1'b1;
        k = 0;
        while (done_cnt < 2 && k < 200) begin
            tick();
            k++;
        end
        bus_b.dump_ready = 1'b0;
        chk("dump3_finished", done_cnt, 2);
        chk("dump3_beats", beats, 36);
        idle(2);
        chk("dump3_idle_busy", 32'(bus_b.dump_busy), 0);
`else
        // dump disabled: outputs stay 0, CPU path unaffected
        bus_b.dump_start = 1'b1;
        bus_b.dump_ready = 1'b1;
        tick();
        bus_b.dump_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_b(i, DW'(i * 3));
            chk("off_dump_valid", 32'(bus_b.dump_valid), 0);
            chk("off_dump_busy", 32'(bus_b.dump_busy), 0);
            chk("off_dump_done", 32'(bus_b.dump_done), 0);
            chk("off_dump_addr", 32'(bus_b.dump_addr), 0);
            chk("off_dump_data", 32'(bus_b.dump_data), 0);
        end
        bus_b.dump_ready = 1'b0;
        idle(5);
        chk("b_queue_drained", exp_b_q.size(), 0);
        chk("off_done_count", done_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
